// File: rtl/router_output_allocator.sv
// Per-output-port switch allocator: round-robin head-flit arbitration, wormhole
// locking until the tail flit, and downstream credit tracking with same-cycle bypass.
module router_output_allocator #(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
  parameter int SEL_WIDTH         = $clog2(NUM_INPUTS)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc_sync,
  input  logic [NUM_INPUTS-1:0]   req,
  input  logic [NUM_INPUTS-1:0]   req_is_tail,
  input  logic [NUM_INPUTS-1:0]   turn_disable,
  output logic [NUM_INPUTS-1:0]   grant,
  input  logic                    credit_in,
  output logic                    send_out,
  output logic                    is_tail_out,
  output logic [SEL_WIDTH-1:0]    sel_out,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    locked,
  output logic                    err_credit_overflow
);

  // Handshake: req[i] is the valid of input i's buffer head; grant[i] is its ready,
  // and a flit moves (input pops, link sends) in exactly the cycles where both are high.
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                state;
  logic [SEL_WIDTH-1:0]  rr_ptr;
  logic [SEL_WIDTH-1:0]  owner;
  logic [NUM_INPUTS-1:0] eligible;
  logic                  can_send;
  logic                  found;
  logic                  fire;
  logic                  grant_tail;
  logic [SEL_WIDTH-1:0]  pick;
  logic [SEL_WIDTH-1:0]  grant_idx;
  int                    scan_idx;

  assign locked = (state == LOCKED);

  always_comb begin
    eligible = req & ~turn_disable;
    can_send = (credit_count != '0) || credit_in;
    found    = 1'b0;
    pick     = rr_ptr;
    scan_idx = 0;
    // Scan from farthest to nearest so the closest eligible input at/after rr_ptr wins.
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_INPUTS;
      if (eligible[scan_idx]) begin
        found = 1'b1;
        pick  = SEL_WIDTH'(scan_idx);
      end
    end
    grant_idx = (state == LOCKED) ? owner : pick;
    grant     = '0;
    if (!rst_noc_sync && can_send) begin
      if (state == LOCKED) grant[owner] = req[owner];
      else if (found)      grant[pick]  = 1'b1;
    end
    fire       = |grant;
    grant_tail = req_is_tail[grant_idx];
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      owner               <= '0;
      credit_count        <= CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
      send_out            <= 1'b0;
      is_tail_out         <= 1'b0;
      sel_out             <= '0;
      err_credit_overflow <= 1'b0;
    end else begin
      if (fire && !credit_in) begin
        credit_count <= credit_count - CREDIT_WIDTH'(1);
      end else if (!fire && credit_in) begin
        if (credit_count == CREDIT_WIDTH'(FLIT_BUFFER_DEPTH)) err_credit_overflow <= 1'b1;
        else credit_count <= credit_count + CREDIT_WIDTH'(1);
      end

      send_out    <= fire;
      is_tail_out <= fire && grant_tail;
      if (fire) sel_out <= grant_idx;

      case (state)
        IDLE: begin
          if (fire) begin
            rr_ptr <= (pick == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0 : pick + SEL_WIDTH'(1);
            if (!grant_tail) begin
              state <= LOCKED;
              owner <= pick;
            end
          end
        end
        LOCKED: begin
          if (fire && grant_tail) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_output_allocator.sv
// Bench for router_output_allocator: directed scenarios plus randomized packet traffic,
// checked against a packet-level reference model and a send_out scoreboard.
module tb_router_output_allocator;
  localparam int N  = 5;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);
  localparam int SW = $clog2(N);
  localparam int W  = SW + 1;

  logic          clk_noc = 1'b0;
  logic          rst_noc_sync = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_is_tail = '0;
  logic [N-1:0]  turn_disable = '0;
  logic [N-1:0]  grant;
  logic          credit_in = 1'b0;
  logic          send_out;
  logic          is_tail_out;
  logic [SW-1:0] sel_out;
  logic [CW-1:0] credit_count;
  logic          locked;
  logic          err_credit_overflow;

  router_output_allocator #(.NUM_INPUTS(N), .FLIT_BUFFER_DEPTH(D)) dut (
    .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync), .req(req), .req_is_tail(req_is_tail),
    .turn_disable(turn_disable), .grant(grant), .credit_in(credit_in), .send_out(send_out),
    .is_tail_out(is_tail_out), .sel_out(sel_out), .credit_count(credit_count),
    .locked(locked), .err_credit_overflow(err_credit_overflow)
  );

  // Clock / reset
  always #5 clk_noc = ~clk_noc;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: packet ownership, round-robin start point, credits, sticky error
  bit m_locked;
  int m_owner;
  int m_rr;
  int m_cred;
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every forwarded flit must match the oldest expected (tail, sel) pair
  always @(negedge clk_noc) begin
    if (send_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_out: unexpected flit sel=%0d at %0t", sel_out, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("flit_tail_sel", {is_tail_out, sel_out}, e);
      end
    end
  end

  // One clock cycle: drive, check combinational grant and current registers, advance model
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] t, input logic c,
                      input logic rs, output int g);
    int best;
    int bestd;
    logic [N-1:0] exp_grant;
    req = r; req_is_tail = t; credit_in = c; rst_noc_sync = rs;
    #1;
    g = -1;
    if (!rs && (m_cred > 0 || c)) begin
      if (m_locked) begin
        if (r[m_owner]) g = m_owner;
      end else begin
        best = -1; bestd = N;
        for (int i = 0; i < N; i++)
          if (r[i] && !turn_disable[i] && ((i - m_rr + N) % N) < bestd) begin
            bestd = (i - m_rr + N) % N;
            best  = i;
          end
        g = best;
      end
    end
    exp_grant = (g >= 0) ? N'(1) << g : '0;
    check("grant", 32'(grant), 32'(exp_grant));
    if (!rs) begin
      check("credit_count", 32'(credit_count), 32'(m_cred));
      check("locked", 32'(locked), 32'(m_locked));
      check("err_credit_overflow", 32'(err_credit_overflow), 32'(m_err));
    end
    if (rs) begin
      m_locked = 0; m_owner = 0; m_rr = 0; m_cred = D; m_err = 0;
    end else begin
      if (g >= 0) begin
        exp_q.push_back({t[g], SW'(g)});
        m_cred = m_cred - 1 + int'(c);
        if (m_locked) begin
          if (t[g]) m_locked = 0;
        end else begin
          m_rr = (g + 1) % N;
          if (!t[g]) begin m_locked = 1; m_owner = g; end
        end
      end else if (c) begin
        if (m_cred == D) m_err = 1;
        else m_cred++;
      end
    end
    @(posedge clk_noc);
    #1;
  endtask

  task automatic do_reset();
    int g;
    step('0, '0, 1'b0, 1'b1, g);
    step('0, '0, 1'b0, 1'b1, g);
  endtask

  // Random traffic: each input holds a packet with rem[i] flits left
  task automatic random_phase(input int cycles);
    int rem[N];
    int g;
    logic [N-1:0] r, t;
    logic c;
    for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 4);
    for (int k = 0; k < cycles; k++) begin
      for (int i = 0; i < N; i++) begin
        r[i] = ($urandom_range(0, 3) != 0);
        t[i] = (rem[i] == 1);
      end
      c = (m_cred < D) && ($urandom_range(0, 2) != 0);
      step(r, t, c, 1'b0, g);
      if (g >= 0) begin
        rem[g]--;
        if (rem[g] == 0) rem[g] = $urandom_range(1, 4);
      end
    end
  endtask

  initial begin
    int g;
    do_reset();

    // Two single-flit packets from inputs 1 and 2
    step(5'b00110, 5'b11111, 1'b0, 1'b0, g);
    step(5'b00100, 5'b11111, 1'b0, 1'b0, g);
    step(5'b01000, 5'b11111, 1'b0, 1'b0, g);  // rr_ptr=3 picks input 3
    check("rr_after_two", 32'(g), 32'd3);

    // Three-flit packet from input 0 holds the link against all other requests
    do_reset();
    for (int f = 0; f < 3; f++) step(5'b11111, {4'b1111, f == 2}, 1'b1, 1'b0, g);
    step(5'b11111, 5'b11111, 1'b1, 1'b0, g);
    check("after_lock_input1", 32'(g), 32'd1);

    // Credit exhaustion and same-cycle bypass
    do_reset();
    for (int f = 0; f < 4; f++) step(5'b00100, 5'b00000, 1'b0, 1'b0, g);
    step(5'b00100, 5'b00000, 1'b0, 1'b0, g);
    check("no_credit_no_grant", 32'(g), 32'hffffffff);
    step(5'b00100, 5'b00000, 1'b1, 1'b0, g);
    check("bypass_grant", 32'(g), 32'd2);
    step(5'b00100, 5'b00100, 1'b1, 1'b0, g);
    step(5'b00000, 5'b00000, 1'b0, 1'b0, g);

    // Forbidden turn never wins head arbitration
    do_reset();
    turn_disable = 5'b01000;
    for (int k = 0; k < 10; k++) step(5'b01000, 5'b11111, 1'b0, 1'b0, g);
    step(5'b01001, 5'b11111, 1'b0, 1'b0, g);
    check("turn_disable_skip", 32'(g), 32'd0);
    turn_disable = '0;

    // Credit overflow is sticky until reset
    do_reset();
    step(5'b00000, 5'b00000, 1'b1, 1'b0, g);
    for (int k = 0; k < 3; k++) step(5'b00000, 5'b00000, 1'b0, 1'b0, g);
    do_reset();
    step(5'b00000, 5'b00000, 1'b0, 1'b0, g);

    // Reset in the middle of a 4-flit packet from input 1
    do_reset();
    step(5'b00010, 5'b00000, 1'b0, 1'b0, g);
    step(5'b00010, 5'b00000, 1'b0, 1'b1, g);
    step(5'b11111, 5'b11111, 1'b0, 1'b0, g);
    check("post_reset_from_0", 32'(g), 32'd0);

    // Randomized traffic under several turn-disable configurations
    for (int p = 0; p < 4; p++) begin
      do_reset();
      turn_disable = (p == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
      random_phase(600);
    end

    step('0, '0, 1'b0, 1'b0, g);
    step('0, '0, 1'b0, 1'b0, g);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/router_output_allocator.md
Name: router_output_allocator

Overview:
- Per-output-port switch allocator for the NoC router; one instance per output port, NUM_OUTPUTS instances per router.
- Shares one output link between NUM_INPUTS input buffers using round-robin head-flit arbitration with wormhole locking until the tail flit.
- Tracks downstream credits, initialised to the downstream FLIT_BUFFER_DEPTH, and never issues a flit without a credit.
- Applies the per-input turn-disable mask at head-flit arbitration only.

Parameters:
- NUM_INPUTS, 5, number of requesting input ports (index 0 = local injection port).
- FLIT_BUFFER_DEPTH, 4, downstream input buffer depth; initial and maximum credit count.
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width.
- SEL_WIDTH, $clog2(NUM_INPUTS), owner/pointer index width.

Ports:
- clk_noc  in  1  NoC clock.
- rst_noc_sync  in  1  reset; synchronous, active-high.
- req  in  NUM_INPUTS  input i has a valid flit at its buffer head routed to this output.
- req_is_tail  in  NUM_INPUTS  the head flit of input i is a tail flit.
- turn_disable  in  NUM_INPUTS  1 = the turn from input i to this output is forbidden; static config.
- grant  out  NUM_INPUTS  one-hot, combinational; input i pops its head flit this cycle.
- credit_in  in  1  downstream returned one credit.
- send_out  out  1  registered; 1 = one flit was forwarded in the previous cycle.
- is_tail_out  out  1  registered; the tail bit of the flit forwarded in the previous cycle.
- sel_out  out  SEL_WIDTH  registered; crossbar select index for the data/dest mux.
- credit_count  out  CREDIT_WIDTH  current credit count.
- locked  out  1  FSM is in LOCKED.
- err_credit_overflow  out  1  sticky error flag.

Behaviour:
- Reset state: FSM=IDLE, rr_ptr=0, owner=0, credit_count=FLIT_BUFFER_DEPTH, send_out=0, is_tail_out=0, sel_out=0, err_credit_overflow=0.
- grant is 0 throughout reset.
- Reset asserted mid-packet drops the lock immediately; no flit is issued in that cycle.
- Definitions: eligible = req & ~turn_disable; fire = |grant.
- grant is asserted only when credit_count>0, or when credit_count==0 and credit_in=1 (same-cycle credit bypass).
- IDLE state:
  - grant the first eligible bit at or after rr_ptr, searching upward with wrap from NUM_INPUTS-1 to 0.
  - If the granted flit is not a tail: next state LOCKED, owner=granted index.
  - If it is a tail (single-flit packet): stay in IDLE.
  - Either way, rr_ptr=(granted+1) mod NUM_INPUTS.
  - If eligible=0, grant=0 and rr_ptr is unchanged.
- LOCKED state:
  - grant[owner]=req[owner] subject to the credit rule; turn_disable is ignored and all other requests are ignored.
  - Firing a flit with req_is_tail[owner]=1 moves the FSM to IDLE; the next arbitration happens in the following cycle.
  - A bubble in req[owner] holds the lock.
- Credits: next = credit_count - fire + credit_in.
  - Simultaneous fire and credit_in leaves the count unchanged.
  - If credit_in=1 arrives with credit_count==FLIT_BUFFER_DEPTH and no fire, the count saturates and err_credit_overflow is set; it clears only on reset.
- Output register, 1-cycle latency: send_out<=fire, is_tail_out<=tail bit of the granted input, sel_out<=granted index.
  - When fire=0, sel_out holds its value and is_tail_out<=0.
- Throughput: one flit per cycle maximum, back-to-back packets included.

Test Plan:
- Reset, then req=5'b00110, all tails -> grant 5'b00010 in cycle 1, then 5'b00100 in cycle 2; rr_ptr=3; send_out high in cycles 2 and 3; sel_out=1, then 2.
- Input 0 sends a 3-flit packet (tail on flit 3) while req=5'b11111 throughout -> grant=5'b00001 for 3 consecutive cycles with locked=1; then IDLE and input 1 is granted.
- Credits: DEPTH=4, input 2 sends a 6-flit packet, no credit_in -> 4 grants, credit_count=0, grant=0. Then pulse credit_in once -> exactly one grant in that same cycle (bypass) and credit_count stays 0.
- turn_disable=5'b01000, req=5'b01000 -> grant stays 0 for 10 cycles. Then req=5'b01001 -> input 0 is granted.
- With credit_count=4, pulse credit_in with no fire -> credit_count=4 and err_credit_overflow=1, sticky until rst_noc_sync.
- Assert rst_noc_sync during the 2nd flit of a 4-flit packet -> next cycle locked=0, credit_count=4, send_out=0; the arbitration after reset starts from input 0.
